wb_regfile: RTL and testbench

Writeback stage plus architectural register file for the five-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback value (ALU result, load data, or link address PC+4), and commits it to a 32×32 register file. Serves the two decode-stage read ports with write-before-read bypass. Exports the selected writeback value for EX-stage forwarding.

---
 rtl/wb_regfile_pkg.sv | 15 +
 rtl/wb_regfile_core.sv | 47 ++++
 rtl/wb_regfile.sv | 65 ++++++
 tb/tb_wb_regfile.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared writeback definitions: datapath widths and MemToReg source encodings,
// common to the MEM/WB register, forwarding unit and writeback stage.
package wb_regfile_pkg;

    localparam int unsigned WbDataWidth = 32;
    localparam int unsigned WbAddrWidth = 5;

    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,
        MTR_MEM  = 2'b01,
        MTR_LINK = 2'b10,
        MTR_RSVD = 2'b11
    } mtr_sel_e;

endpackage

// File: rtl/wb_regfile_core.sv
// Architectural register storage: synchronous clear, one write port, two raw
// read ports. Index 0 always reads as zero.
module wb_regfile_core
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WbDataWidth,
    parameter int unsigned ADDR_WIDTH = WbAddrWidth,
    parameter int unsigned NUM_REGS   = 2 ** WbAddrWidth
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    // Reset wins over any write presented in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
        rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
    end

endmodule

// File: rtl/wb_regfile.sv
// MIPS writeback stage: selects the writeback value, commits it to the
// register file and bypasses it to the decode read ports in the same cycle.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WbDataWidth,
    parameter int unsigned ADDR_WIDTH = WbAddrWidth,
    parameter int unsigned NUM_REGS   = 2 ** WbAddrWidth
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            wb_mem_to_reg,
    input  logic                  wb_reg_write,
    input  logic [ADDR_WIDTH-1:0] wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_mem_data,
    input  logic [DATA_WIDTH-1:0] wb_alu_result,
    input  logic [DATA_WIDTH-1:0] wb_link_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_write_en
);

    mtr_sel_e              sel;
    logic [DATA_WIDTH-1:0] raw_data1;
    logic [DATA_WIDTH-1:0] raw_data2;

    assign sel = mtr_sel_e'(wb_mem_to_reg);

    always_comb begin
        wb_data = wb_alu_result;
        case (sel)
            MTR_MEM:  wb_data = wb_mem_data;
            MTR_LINK: wb_data = wb_link_addr;
            default:  wb_data = wb_alu_result;
        endcase
    end

    // Writes to r0 are dropped here so neither storage nor bypass ever sees them.
    assign wb_write_en = wb_reg_write & (wb_dest != '0) & ~reset;

    wb_regfile_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .we_i    (wb_write_en),
        .waddr_i (wb_dest),
        .wdata_i (wb_data),
        .raddr1_i(rd_addr1),
        .raddr2_i(rd_addr2),
        .rdata1_o(raw_data1),
        .rdata2_o(raw_data2)
    );

    always_comb begin
        rd_data1 = (wb_write_en && (rd_addr1 == wb_dest)) ? wb_data : raw_data1;
        rd_data2 = (wb_write_en && (rd_addr2 == wb_dest)) ? wb_data : raw_data2;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: array model checked every cycle plus
// directed vectors with hand-computed expectations.
module tb_wb_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  wb_mem_to_reg;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_link_addr;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] wb_data;
    logic        wb_write_en;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    logic [31:0] mregs [32];

    wb_regfile dut (
        .clock        (clock),
        .reset        (reset),
        .wb_mem_to_reg(wb_mem_to_reg),
        .wb_reg_write (wb_reg_write),
        .wb_dest      (wb_dest),
        .wb_mem_data  (wb_mem_data),
        .wb_alu_result(wb_alu_result),
        .wb_link_addr (wb_link_addr),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .wb_data      (wb_data),
        .wb_write_en  (wb_write_en)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] m_wb();
        if (wb_mem_to_reg == 2'd1) return wb_mem_data;
        if (wb_mem_to_reg == 2'd2) return wb_link_addr;
        return wb_alu_result;
    endfunction

    function automatic logic m_we();
        return !reset && wb_reg_write && (wb_dest != 5'd0);
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_we() && a == wb_dest) return m_wb();
        return mregs[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
        end else if (m_we()) begin
            mregs[wb_dest] <= m_wb();
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_rd1", rd_data1, m_rd(rd_addr1));
            check("model_rd2", rd_data2, m_rd(rd_addr2));
            check("model_wbdata", wb_data, m_wb());
            check("model_we", {31'd0, wb_write_en}, {31'd0, m_we()});
        end
    end

    task automatic set_in(input logic rst, input logic [1:0] sel, input logic we,
                          input logic [4:0] dest, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [31:0] link,
                          input logic [4:0] a1, input logic [4:0] a2);
        reset = rst; wb_mem_to_reg = sel; wb_reg_write = we; wb_dest = dest;
        wb_alu_result = alu; wb_mem_data = mem; wb_link_addr = link;
        rd_addr1 = a1; rd_addr2 = a2;
        @(negedge clock);
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] sel_exp [4];
        sel_exp[0] = 32'h11111111; sel_exp[1] = 32'h22222222;
        sel_exp[2] = 32'h00400008; sel_exp[3] = 32'h11111111;

        set_in(1'b1, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        advance();
        chk_en = 1'b1;

        // Reset: fill r1..r31, then one reset cycle with a write to r9.
        for (int i = 1; i < 32; i++) begin
            set_in(1'b0, 2'd0, 1'b1, 5'(i), $urandom | 32'h1, 32'd0, 32'd0, 5'(i), 5'(i));
            advance();
        end
        set_in(1'b1, 2'd0, 1'b1, 5'd9, 32'h55555555, 32'd0, 32'd0, 5'd9, 5'd9);
        check("rst_we", {31'd0, wb_write_en}, 32'd0);
        check("rst_wbdata", wb_data, 32'h55555555);
        advance();
        for (int i = 1; i < 32; i++) begin
            set_in(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'(i), 5'(32 - i));
            check("rst_clear1", rd_data1, 32'd0);
            check("rst_clear2", rd_data2, 32'd0);
            advance();
        end
        set_in(1'b0, 2'd0, 1'b1, 5'd9, 32'h55555555, 32'd0, 32'd0, 5'd1, 5'd2);
        advance();
        set_in(1'b0, 2'd0, 1'b0, 5'd9, 32'd0, 32'd0, 32'd0, 5'd9, 5'd0);
        check("rst_after_write", rd_data1, 32'h55555555);
        advance();

        // Source select on r8.
        for (int s = 0; s < 4; s++) begin
            set_in(1'b0, 2'(s), 1'b1, 5'd8, 32'h11111111, 32'h22222222, 32'h00400008,
                   5'd8, 5'd0);
            check("sel_bypass", rd_data1, sel_exp[s]);
            advance();
            set_in(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd8, 5'd8);
            check("sel_stored", rd_data2, sel_exp[s]);
            advance();
        end

        // Bypass to both ports, then read from storage.
        set_in(1'b0, 2'd1, 1'b1, 5'd5, 32'd0, 32'hDEADBEEF, 32'd0, 5'd5, 5'd5);
        check("byp_rd1", rd_data1, 32'hDEADBEEF);
        check("byp_rd2", rd_data2, 32'hDEADBEEF);
        advance();
        set_in(1'b0, 2'd0, 1'b0, 5'd5, 32'd0, 32'd0, 32'd0, 5'd5, 5'd5);
        check("byp_hold1", rd_data1, 32'hDEADBEEF);
        check("byp_hold2", rd_data2, 32'hDEADBEEF);
        advance();

        // Register 0 write is ignored.
        set_in(1'b0, 2'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd0, 5'd0);
        check("r0_rd", rd_data1, 32'd0);
        check("r0_we", {31'd0, wb_write_en}, 32'd0);
        advance();
        set_in(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        check("r0_after", rd_data2, 32'd0);
        advance();

        // Bubble leaves r3 untouched.
        set_in(1'b0, 2'd0, 1'b1, 5'd3, 32'hAAAA0000, 32'd0, 32'd0, 5'd0, 5'd0);
        advance();
        set_in(1'b0, 2'd0, 1'b0, 5'd3, 32'h12345678, 32'd0, 32'd0, 5'd3, 5'd0);
        check("bubble_rd", rd_data1, 32'hAAAA0000);
        check("bubble_we", {31'd0, wb_write_en}, 32'd0);
        advance();
        set_in(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3);
        check("bubble_hold", rd_data2, 32'hAAAA0000);
        advance();

        // Back-to-back writes to r4: each visible in its own cycle, last wins.
        for (int k = 1; k <= 3; k++) begin
            set_in(1'b0, 2'd2, 1'b1, 5'd4, 32'd0, 32'd0, 32'(k * 16'h1111), 5'd4, 5'd3);
            check("b2b_bypass", rd_data1, 32'(k * 16'h1111));
            advance();
        end
        set_in(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd4, 5'd4);
        check("b2b_last", rd_data1, 32'h00003333);
        advance();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
